// File: rtl/pwm_breathe_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_breathe_ctrl
//
// Breathing-LED duty sequencer. A free-running 101-cycle frame counter is
// shared with the downstream PWM comparator (led on while frame_cnt < duty).
// Once per frame (frame_cnt == 100) the FSM ramps an internal linear level
// up, holds it high, ramps it down and holds it low, as long as en stays high.
//
// Optional feature: define BREATHE_GAMMA_EN to drive duty through the
// perceptual map (lin*lin*41) >> 12 instead of the linear level.
//
// Ports
//   clk          system clock, all logic on its rising edge
//   rst          asynchronous, active-high reset
//   en           breathing enable, only looked at on frame boundaries
//   duty[6:0]    registered duty value 0..100
//   frame_cnt    shared PWM frame counter 0..100
//   frame_start  high while frame_cnt == 0
//   phase[2:0]   FSM state (IDLE=0, UP=1, HOLD_HI=2, DOWN=3, HOLD_LO=4)
//
// State   | meaning
// IDLE    | breathing off, level 0
// UP      | level rises by STEP on each step event
// HOLD_HI | level parked at 100 for HOLD_STEPS step events
// DOWN    | level falls by STEP on each step event
// HOLD_LO | level parked at 0 for HOLD_STEPS step events
// -----------------------------------------------------------------------------
module pwm_breathe_ctrl #(
    parameter int STEP            = 5,
    parameter int FRAMES_PER_STEP = 4,
    parameter int HOLD_STEPS      = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [6:0] duty,
    output logic [6:0] frame_cnt,
    output logic       frame_start,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP      = 3'd1,
        HOLD_HI = 3'd2,
        DOWN    = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

    localparam logic [7:0] STEP_L    = 8'(STEP);
    localparam logic [7:0] FPS_LAST  = 8'(FRAMES_PER_STEP - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_STEPS - 1);
    localparam logic [7:0] LIN_MAX   = 8'd100;

    state_t     state, state_nxt;
    // 8-bit level so lin + STEP (max 200) never wraps before the saturation test
    logic [7:0] lin, lin_nxt;
    logic [7:0] step_cnt, step_cnt_nxt;
    logic [7:0] hold_cnt, hold_cnt_nxt;
    logic [6:0] duty_nxt;
    logic       boundary;
    logic       step_evt;

    assign boundary    = (frame_cnt == 7'd100);
    assign step_evt    = (step_cnt == FPS_LAST);
    assign frame_start = (frame_cnt == 7'd0);
    assign phase       = state;

    always_comb begin
        state_nxt    = state;
        lin_nxt      = lin;
        step_cnt_nxt = step_cnt;
        hold_cnt_nxt = hold_cnt;
        if (boundary) begin
            if (!en) begin
                // disable wins over any step event on the same boundary
                state_nxt    = IDLE;
                lin_nxt      = 8'd0;
                step_cnt_nxt = 8'd0;
                hold_cnt_nxt = 8'd0;
            end else begin
                step_cnt_nxt = step_evt ? 8'd0 : step_cnt + 8'd1;
                case (state)
                    IDLE: begin
                        state_nxt    = UP;
                        lin_nxt      = 8'd0;
                        step_cnt_nxt = 8'd0;
                        hold_cnt_nxt = 8'd0;
                    end
                    UP: begin
                        if (step_evt) begin
                            if (lin + STEP_L >= LIN_MAX) begin
                                lin_nxt      = LIN_MAX;
                                state_nxt    = HOLD_HI;
                                hold_cnt_nxt = 8'd0;
                            end else begin
                                lin_nxt = lin + STEP_L;
                            end
                        end
                    end
                    HOLD_HI: begin
                        if (step_evt) begin
                            if (hold_cnt == HOLD_LAST) begin
                                state_nxt    = DOWN;
                                hold_cnt_nxt = 8'd0;
                            end else begin
                                hold_cnt_nxt = hold_cnt + 8'd1;
                            end
                        end
                    end
                    DOWN: begin
                        if (step_evt) begin
                            if (lin <= STEP_L) begin
                                lin_nxt      = 8'd0;
                                state_nxt    = HOLD_LO;
                                hold_cnt_nxt = 8'd0;
                            end else begin
                                lin_nxt = lin - STEP_L;
                            end
                        end
                    end
                    HOLD_LO: begin
                        if (step_evt) begin
                            if (hold_cnt == HOLD_LAST) begin
                                state_nxt    = UP;
                                hold_cnt_nxt = 8'd0;
                            end else begin
                                hold_cnt_nxt = hold_cnt + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state_nxt    = IDLE;
                        lin_nxt      = 8'd0;
                        step_cnt_nxt = 8'd0;
                        hold_cnt_nxt = 8'd0;
                    end
                endcase
            end
        end
    end

`ifdef BREATHE_GAMMA_EN
    // 19-bit product: 100*100*41 = 410000 < 2^19
    always_comb begin
        duty_nxt = 7'((19'(lin_nxt) * 19'(lin_nxt) * 19'd41) >> 12);
    end
`else
    always_comb begin
        duty_nxt = lin_nxt[6:0];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 7'd0;
            state     <= IDLE;
            lin       <= 8'd0;
            step_cnt  <= 8'd0;
            hold_cnt  <= 8'd0;
            duty      <= 7'd0;
        end else begin
            frame_cnt <= boundary ? 7'd0 : frame_cnt + 7'd1;
            state     <= state_nxt;
            lin       <= lin_nxt;
            step_cnt  <= step_cnt_nxt;
            hold_cnt  <= hold_cnt_nxt;
            if (boundary) begin
                duty <= duty_nxt;
            end
        end
    end

endmodule

// File: tb/tb_pwm_breathe_ctrl.sv
module tb_pwm_breathe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_a, en_b;
    logic [6:0] duty_a, fc_a, duty_b, fc_b;
    logic       fs_a, fs_b;
    logic [2:0] ph_a, ph_b;

    always #5 clk = ~clk;

    pwm_breathe_ctrl dut_a (
        .clk(clk), .rst(rst), .en(en_a),
        .duty(duty_a), .frame_cnt(fc_a), .frame_start(fs_a), .phase(ph_a)
    );

    pwm_breathe_ctrl #(.STEP(30), .FRAMES_PER_STEP(1), .HOLD_STEPS(2)) dut_b (
        .clk(clk), .rst(rst), .en(en_b),
        .duty(duty_b), .frame_cnt(fc_b), .frame_start(fs_b), .phase(ph_b)
    );

    // reference model: one update per frame boundary
    typedef struct {
        int ph;    // 0 idle, 1 up, 2 hold high, 3 down, 4 hold low
        int lin;
        int fc;    // frames elapsed in the current step
        int hc;    // step events completed in the current hold
    } mdl_t;

    typedef struct {
        bit en;
        int ph;
        int lin;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    mdl_t ma, mb;
    vec_t tbl[18];

    function automatic int gam(int l);
`ifdef BREATHE_GAMMA_EN
        return (l * l * 41) / 4096;
`else
        return l;
`endif
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit e, int step, int fps, int hold);
        mdl_t r;
        r = m;
        if (!e) begin
            r = '{0, 0, 0, 0};
            return r;
        end
        if (m.ph == 0) begin
            r = '{1, 0, 0, 0};
            return r;
        end
        r.fc = m.fc + 1;
        if (r.fc < fps) return r;
        r.fc = 0;
        case (m.ph)
            1: begin
                if (m.lin + step >= 100) begin r.lin = 100; r.ph = 2; r.hc = 0; end
                else r.lin = m.lin + step;
            end
            2: begin
                r.hc = m.hc + 1;
                if (r.hc == hold) begin r.ph = 3; r.hc = 0; end
            end
            3: begin
                if (m.lin <= step) begin r.lin = 0; r.ph = 4; r.hc = 0; end
                else r.lin = m.lin - step;
            end
            default: begin
                r.hc = m.hc + 1;
                if (r.hc == hold) begin r.ph = 1; r.hc = 0; end
            end
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_a();
        chk("a_phase", int'(ph_a), ma.ph);
        chk("a_duty", int'(duty_a), gam(ma.lin));
        chk("a_frame_cnt", int'(fc_a), 0);
        chk("a_frame_start", int'(fs_a), 1);
    endtask

    task automatic cmp_b();
        chk("b_phase", int'(ph_b), mb.ph);
        chk("b_duty", int'(duty_b), gam(mb.lin));
        chk("b_frame_cnt", int'(fc_b), 0);
    endtask

    // one full frame starting #1 after a boundary edge, ending #1 after the next
    task automatic frame(input bit use_b);
        repeat (50) @(posedge clk);
        #1;
        chk("a_mid_frame_cnt", int'(fc_a), 50);
        chk("a_mid_duty", int'(duty_a), gam(ma.lin));
        chk("b_mid_duty", int'(duty_b), gam(mb.lin));
        repeat (51) @(posedge clk);
        #1;
        ma = mstep(ma, en_a, 5, 4, 10);
        mb = mstep(mb, en_b, 30, 1, 2);
        cmp_a();
        if (use_b) cmp_b();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a_frame_cnt"}, int'(fc_a), 0);
        chk({tag, "_a_duty"}, int'(duty_a), 0);
        chk({tag, "_a_phase"}, int'(ph_a), 0);
        chk({tag, "_a_frame_start"}, int'(fs_a), 1);
        chk({tag, "_b_duty"}, int'(duty_b), 0);
        chk({tag, "_b_phase"}, int'(ph_b), 0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1, 0};
        tbl[1]  = '{1'b1, 1, 30};
        tbl[2]  = '{1'b1, 1, 60};
        tbl[3]  = '{1'b1, 1, 90};
        tbl[4]  = '{1'b1, 2, 100};
        tbl[5]  = '{1'b1, 2, 100};
        tbl[6]  = '{1'b1, 3, 100};
        tbl[7]  = '{1'b1, 3, 70};
        tbl[8]  = '{1'b1, 3, 40};
        tbl[9]  = '{1'b1, 3, 10};
        tbl[10] = '{1'b1, 4, 0};
        tbl[11] = '{1'b1, 4, 0};
        tbl[12] = '{1'b1, 1, 0};
        tbl[13] = '{1'b1, 1, 30};
        tbl[14] = '{1'b0, 0, 0};
        tbl[15] = '{1'b0, 0, 0};
        tbl[16] = '{1'b1, 1, 0};
        tbl[17] = '{1'b1, 1, 30};

        ma = '{0, 0, 0, 0};
        mb = '{0, 0, 0, 0};
        en_a = 1'b1;
        en_b = tbl[0].en;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk_zero("por");
        @(negedge clk);
        rst = 1'b0;

        // first boundary lands exactly 101 edges after release
        repeat (100) @(posedge clk);
        #1;
        chk("first_pre_frame_cnt", int'(fc_a), 100);
        chk("first_pre_phase", int'(ph_a), 0);
        chk("first_pre_frame_start", int'(fs_a), 0);
        @(posedge clk);
        #1;
        ma = mstep(ma, en_a, 5, 4, 10);
        mb = mstep(mb, en_b, 30, 1, 2);
        cmp_a();
        chk("first_a_phase", int'(ph_a), 1);
        chk("first_a_duty", int'(duty_a), 0);
        chk("tbl_b_phase", int'(ph_b), tbl[0].ph);
        chk("tbl_b_duty", int'(duty_b), gam(tbl[0].lin));

        // frames 2..18: instance B follows the vector table
        for (int i = 1; i < 18; i++) begin
            en_b = tbl[i].en;
            frame(1'b0);
            chk("tbl_b_phase", int'(ph_b), tbl[i].ph);
            chk("tbl_b_duty", int'(duty_b), gam(tbl[i].lin));
        end

        // frames 19..277: one full breathing cycle of A, B randomized
        for (int f = 19; f <= 277; f++) begin
            en_b = ($urandom_range(0, 7) != 0);
            frame(1'b1);
            if (f == 80)  begin chk("f80_phase", int'(ph_a), 1); chk("f80_duty", int'(duty_a), gam(95)); end
            if (f == 81)  begin chk("f81_phase", int'(ph_a), 2); chk("f81_duty", int'(duty_a), gam(100)); end
            if (f == 120) chk("f120_phase", int'(ph_a), 2);
            if (f == 121) begin chk("f121_phase", int'(ph_a), 3); chk("f121_duty", int'(duty_a), gam(100)); end
            if (f == 125) chk("f125_duty", int'(duty_a), gam(95));
            if (f == 201) begin chk("f201_phase", int'(ph_a), 4); chk("f201_duty", int'(duty_a), 0); end
            if (f == 241) begin chk("f241_phase", int'(ph_a), 1); chk("f241_duty", int'(duty_a), 0); end
            if (f == 277) begin chk("f277_phase", int'(ph_a), 1); chk("f277_duty", int'(duty_a), gam(45)); end
        end

        // asynchronous reset between edges while ramping at level 45
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        ma = '{0, 0, 0, 0};
        mb = '{0, 0, 0, 0};
        @(negedge clk);
        rst = 1'b0;
        en_b = 1'b1;

        // fresh ramp after reset must match power-on behaviour
        for (int f = 1; f <= 37; f++) frame(1'b1);
        chk("rerun_phase", int'(ph_a), 1);
        chk("rerun_duty", int'(duty_a), gam(45));

        // en dropped mid-frame: duty holds until the boundary
        repeat (50) @(posedge clk);
        #1;
        en_a = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("drop_pre_frame_cnt", int'(fc_a), 100);
        chk("drop_pre_duty", int'(duty_a), gam(45));
        chk("drop_pre_phase", int'(ph_a), 1);
        @(posedge clk);
        #1;
        ma = mstep(ma, en_a, 5, 4, 10);
        mb = mstep(mb, en_b, 30, 1, 2);
        cmp_a();
        cmp_b();
        chk("drop_phase", int'(ph_a), 0);
        chk("drop_duty", int'(duty_a), 0);
        frame(1'b1);

        // randomized enable pattern against the model
        for (int f = 0; f < 120; f++) begin
            en_a = ($urandom_range(0, 15) != 0);
            en_b = ($urandom_range(0, 5) != 0);
            frame(1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_breathe_ctrl.md
PWM_BREATHE_CTRL -- requirements
Module: pwm_breathe_ctrl

Interface
REQ-001 Parameter STEP, default 5, duty increment/decrement per ramp step, legal range 1..100.
REQ-002 Parameter FRAMES_PER_STEP, default 4, PWM frames per ramp step, legal range 1..255.
REQ-003 Parameter HOLD_STEPS, default 10, step events spent in each hold state, legal range 1..255.
REQ-004 clk  input  1  single clock; all sequential logic on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 en  input  1  breathing enable, level-sensitive, sampled only at frame boundaries.
REQ-007 duty  output  7  duty value 0..100 for the downstream PWM comparator (led high while frame_cnt < duty).
REQ-008 frame_cnt  output  7  shared PWM frame counter 0..100.
REQ-009 frame_start  output  1  high in every cycle where frame_cnt == 0.
REQ-010 phase  output  3  FSM state: IDLE=0, UP=1, HOLD_HI=2, DOWN=3, HOLD_LO=4.

Function
REQ-011 frame_cnt SHALL increment by 1 every clk regardless of en; 100 wraps to 0 (101-cycle frame).
REQ-012 Frame boundary = clock edge where frame_cnt == 100; all FSM, step-counter, internal linear level (lin) and duty updates SHALL occur only on this edge, so they become visible with frame_start.
REQ-013 Frame counter within a step SHALL count boundaries; a step event occurs on the boundary where it equals FRAMES_PER_STEP-1, then it clears; it also clears on every phase change.
REQ-014 IDLE: lin=0; on a boundary with en=1 go to UP with lin=0.
REQ-015 UP: on step event lin += STEP; if lin+STEP >= 100 then lin=100, go to HOLD_HI.
REQ-016 HOLD_HI: lin held; after HOLD_STEPS step events go to DOWN.
REQ-017 DOWN: on step event lin -= STEP; if lin <= STEP then lin=0, go to HOLD_LO.
REQ-018 HOLD_LO: lin held at 0; after HOLD_STEPS step events go to UP.
REQ-019 On any boundary with en=0 in a non-IDLE phase: phase=IDLE, lin=0, all step/hold counters cleared; takes priority over a coincident step event.
REQ-020 Hold counter SHALL clear on entry to HOLD_HI/HOLD_LO.
REQ-021 duty SHALL be registered, equal to lin (or its gamma mapping per REQ-026), never exceed 100, and never change except at a frame boundary.
REQ-022 lin arithmetic SHALL use at least 8 bits so lin+STEP cannot overflow before the saturation compare.

Reset
REQ-023 While rst=1, immediately and without a clock edge: frame_cnt=0, duty=0, phase=IDLE, lin=0, all internal counters 0; frame_start consequently reads 1.
REQ-024 Reset asserted mid-ramp SHALL discard all progress; after release, behaviour SHALL be identical to power-on.
REQ-025 First frame boundary after rst release SHALL occur 101 clk edges later.

Configuration
REQ-026 Macro BREATHE_GAMMA_EN defined: duty = (lin*lin*41) >> 12 using >=19-bit intermediate (lin 50 -> 25, lin 100 -> 100); phase transitions still use lin.
REQ-027 Macro BREATHE_GAMMA_EN undefined: duty = lin, no multiplier synthesized.

Verification (defaults unless stated, gamma off)
REQ-028 rst pulse asynchronous between clk edges during UP with duty=45 -> duty=0, frame_cnt=0, phase=0 before the next clk edge.
REQ-029 en=1 from reset -> phase=1, duty=0 at first frame_start (cycle 101); duty=5 four frames later; duty=100, phase=2 after 20 step events (80 frames after entering UP).
REQ-030 Continue -> HOLD_HI lasts 40 frames, then phase=3; duty=95 four frames later; reaches 0 and phase=4 after 20 steps; phase=1 40 frames later.
REQ-031 STEP=30 -> duty sequence 0,30,60,90,100 in UP and 100,70,40,10,0 in DOWN.
REQ-032 en dropped mid-frame during UP at duty=45 -> duty holds 45 until frame boundary, then duty=0, phase=0; frame_cnt continues wrapping uninterrupted.
REQ-033 BREATHE_GAMMA_EN defined, STEP=25 -> duty sequence 0,6,25,56,100 while lin is 0,25,50,75,100.
